crt_fb_scan_arbiter: RTL and testbench
======================================

Name: crt_fb_scan_arbiter

Overview:
- Shares one single-port 1-bit framebuffer RAM (40x6 CRT cells) between two users:
  - the display scanout, which fetches the pixel for each cell just ahead of the beam;
  - a pixel-write client.
- Also runs a full-buffer clear sequence on request.
- Sits between the 640x480 timing generator (sx/sy/de) and the registered RGB output pads.
- Each cell maps to a 16x80 screen block.

Parameters:
- H_RES, 640, active pixels per line
- H_TOTAL, 800, total pixels per line
- V_RES, 480, active lines
- V_TOTAL, 525, total lines
- CELL_W, 16, screen pixels per cell horizontally; power of two
- CELL_H, 80, screen lines per cell vertically
- COLS, 40, cells per row
- ROWS, 6, cell rows; COLS*ROWS ≤ 256

Ports:
- clk_pix  in  1  pixel clock, all logic on rising edge
- rst_pix_n  in  1  reset, asynchronous assert, active-low
- sx  in  10  current horizontal position from timing generator
- sy  in  10  current vertical position from timing generator
- de  in  1  data-enable from timing generator
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when high together with wr_valid
- wr_addr  in  8  cell index, row*COLS+col
- wr_data  in  1  pixel value
- clr_req  in  1  single-cycle request to clear the whole buffer
- clr_busy  out  1  clear sequence in progress
- mem_addr  out  8  RAM address (combinational)
- mem_we  out  1  RAM write enable (combinational)
- mem_wdata  out  1  RAM write data (combinational)
- mem_rdata  in  1  RAM read data, valid the cycle after the address (registered-read EBR)
- pix_on  out  1  lit-pixel output for the current sx/sy, gated by de
- frame_start  out  1  one-cycle pulse when sx==0 and sy==0

Behaviour:
- Reset (rst_pix_n low): state IDLE, pixel_q=0, pix_on=0, clr_busy=0, clr_idx=0, frame_start=0.
  - wr_ready and mem_we are 0 while in reset.
- Fetch slot: cell column c is fetched at sx == c*CELL_W-2, computed modulo H_TOTAL.
  - c=0 is fetched at sx=H_TOTAL-2 of the previous line.
  - Target line is sy, or sy+1 for c=0. sy+1 wraps to 0 at V_TOTAL-1.
  - A slot is live only if the target line < V_RES and c < COLS.
  - Target row = target line / CELL_H, by compare chain or counter.
  - Slot cycle drives: mem_addr=row*COLS+c, mem_we=0.
  - The cycle after a slot: pixel_q <= mem_rdata at the clock edge, so pixel_q holds cell c for sx=c*CELL_W .. c*CELL_W+CELL_W-1.
  - pixel_q is held between captures.
- pix_on = pixel_q & de, registered: one cycle latency, aligned with the registered sync path.
- Arbitration priority: fetch slot > clear > write client.
  - Free cycle = any cycle that is not a live fetch slot.
- States:
  - IDLE: wr_ready = !live_slot. On wr_valid&&wr_ready: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data.
    - If wr_addr ≥ COLS*ROWS the write is accepted with mem_we=0 (dropped).
  - IDLE→CLEAR on clr_req: clr_idx=0, clr_busy=1 from the next cycle.
    - A write handshaking in the same cycle as clr_req still completes.
  - CLEAR: wr_ready=0. Each free cycle: mem_addr=clr_idx, mem_we=1, mem_wdata=0, clr_idx++.
    - After writing COLS*ROWS-1 → IDLE, clr_busy=0 the next cycle.
    - During a live slot clr_idx holds.
  - clr_req in CLEAR restarts clr_idx at 0.
- Reset mid-clear: return to IDLE immediately. RAM contents are partially cleared; no recovery.
- frame_start is registered: it pulses the cycle after sx==0 && sy==0.
- Outside any write or clear, mem_we=0 and mem_addr holds the last fetch address.

Test Plan:
- Reset, then RAM preloaded with cell 0=1 and cell 1=0; run line sy=0 → fetch at sx=798 (addr 0) and sx=14 (addr 1); pix_on=1 for sx 0–15 (one-cycle delayed), 0 for sx 16–31.
- Row boundary: cell 40=1, sy=79→80 → addr 40 fetched at sx=798 of line 79; pix_on high from line 80.
- Contention: wr_valid held with wr_addr=5, data=1 across sx=30 → wr_ready=0 at sx=30 (slot, addr 2 read); write lands at sx=31 with mem_we=1, mem_addr=5.
- Clear: clr_req at sx=100 → clr_busy high for exactly 240 + (live slots in window) cycles; all 240 cells read back 0; wr_ready=0 throughout.
- Out of range: wr_addr=250 → handshake completes, mem_we=0; restart clr_req mid-clear → clr_idx returns to 0.
- Async reset asserted mid-clear and mid-line → clr_busy, pix_on, and wr_ready go 0 without a clock edge; after release, the first fetch occurs at the next slot.

Source files
------------

// File: rtl/crt_fb_scan_arbiter.sv
// Purpose : shares one single-port 1-bit framebuffer RAM (COLS x ROWS cells) between the
//           display scanout, a pixel-write client and a whole-buffer clear sequence.
// Latency : each cell is fetched 2 pixels ahead of the beam; pix_on/frame_start are registered (1 cycle).
// Backpr. : fetch slot > clear > write; wr_ready drops on live fetch slots and while clearing,
//           and the clear index stalls on live fetch slots.
// Ports   : clk_pix/rst_pix_n      pixel clock, async active-low reset
//           sx/sy/de               beam position and data-enable from the timing generator
//           wr_valid/wr_ready/wr_addr/wr_data   pixel-write client handshake
//           clr_req/clr_busy       clear request pulse and in-progress flag
//           mem_addr/mem_we/mem_wdata/mem_rdata RAM port (registered-read RAM)
//           pix_on/frame_start     registered lit-pixel and frame-start pulse
module crt_fb_scan_arbiter #(
  parameter int H_RES   = 640,
  parameter int H_TOTAL = 800,
  parameter int V_RES   = 480,
  parameter int V_TOTAL = 525,
  parameter int CELL_W  = 16,
  parameter int CELL_H  = 80,
  parameter int COLS    = 40,
  parameter int ROWS    = 6
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_addr,
  input  logic       wr_data,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic       mem_wdata,
  input  logic       mem_rdata,
  output logic       pix_on,
  output logic       frame_start
);

  localparam int CELL_SH = $clog2(CELL_W);
  localparam int N_CELLS = COLS * ROWS;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_clr_idx;
  logic       r_clr_busy;
  logic [7:0] r_fetch_addr;
  logic       r_fetch_d;
  logic       r_pixel_q;
  logic       r_pix_on;
  logic       r_frame_start;

  logic [10:0] w_sx_p2;
  logic [10:0] w_sx_mod;
  logic [10:0] w_col;
  logic        w_wrap;
  logic        w_slot;
  logic        w_live;
  logic [9:0]  w_tline;
  logic [7:0]  w_row;
  logic [7:0]  w_fetch_addr;
  logic        w_idle;
  logic        w_wr_fire;
  logic        w_wr_in_range;

  // Slot decode: the pixel two clocks ahead of the beam starts a cell when it is a
  // multiple of CELL_W. Looking across the line end makes column 0 target the next line.
  always_comb begin
    w_sx_p2  = {1'b0, sx} + 11'd2;
    w_wrap   = (w_sx_p2 >= 11'(H_TOTAL));
    w_sx_mod = w_wrap ? (w_sx_p2 - 11'(H_TOTAL)) : w_sx_p2;
    w_col    = w_sx_mod >> CELL_SH;
    w_slot   = ((w_sx_mod & 11'(CELL_W - 1)) == 11'd0);

    if (!w_wrap) begin
      w_tline = sy;
    end else if (sy == 10'(V_TOTAL - 1)) begin
      w_tline = 10'd0;
    end else begin
      w_tline = sy + 10'd1;
    end

    // Row by compare chain; avoids a divider on the line number.
    w_row = 8'd0;
    for (int r = 1; r < ROWS; r++) begin
      if (w_tline >= 10'(r * CELL_H)) begin
        w_row = 8'(r);
      end
    end

    w_live       = w_slot && (w_col < 11'(COLS)) && (w_sx_mod < 11'(H_RES)) &&
                   (w_tline < 10'(V_RES));
    w_fetch_addr = w_row * 8'(COLS) + w_col[7:0];
  end

  // Arbitration. Reset gating keeps the RAM and the client quiet while rst_pix_n is low,
  // without waiting for a clock edge.
  always_comb begin
    w_idle        = (r_state == S_IDLE);
    wr_ready      = rst_pix_n && w_idle && !w_live;
    w_wr_fire     = wr_valid && wr_ready;
    w_wr_in_range = (wr_addr < 8'(N_CELLS));

    mem_addr  = r_fetch_addr;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (w_live) begin
      mem_addr = w_fetch_addr;
    end else if (r_state == S_CLEAR) begin
      mem_addr = r_clr_idx;
      mem_we   = rst_pix_n;
    end else if (w_wr_fire) begin
      mem_addr  = wr_addr;
      mem_we    = w_wr_in_range;
      mem_wdata = wr_data;
    end
  end

  // Clear FSM: a clr_req while clearing restarts from cell 0.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_state    <= S_IDLE;
      r_clr_idx  <= 8'd0;
      r_clr_busy <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_state    <= S_CLEAR;
            r_clr_idx  <= 8'd0;
            r_clr_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_req) begin
            r_clr_idx <= 8'd0;
          end else if (!w_live) begin
            if (r_clr_idx == 8'(N_CELLS - 1)) begin
              r_state    <= S_IDLE;
              r_clr_busy <= 1'b0;
              r_clr_idx  <= 8'd0;
            end else begin
              r_clr_idx <= r_clr_idx + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Scanout pipeline: RAM data is valid the cycle after a slot and is captured then,
  // so the pixel register changes exactly at the first pixel of the cell.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      r_fetch_addr  <= 8'd0;
      r_fetch_d     <= 1'b0;
      r_pixel_q     <= 1'b0;
      r_pix_on      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_fetch_d <= w_live;
      if (w_live) begin
        r_fetch_addr <= w_fetch_addr;
      end
      if (r_fetch_d) begin
        r_pixel_q <= mem_rdata;
      end
      r_pix_on      <= r_pixel_q & de;
      r_frame_start <= (sx == 10'd0) && (sy == 10'd0);
    end
  end

  assign clr_busy    = r_clr_busy;
  assign pix_on      = r_pix_on;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_crt_fb_scan_arbiter.sv
module tb_crt_fb_scan_arbiter;

  logic       clk_pix;
  logic       rst_pix_n;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic       wr_data;
  logic       clr_req;
  logic       clr_busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic       mem_wdata;
  logic       mem_rdata;
  logic       pix_on;
  logic       frame_start;

  int total;
  int bad;
  int psx;
  int psy;

  // Physical RAM (registered read) and the bench's expected contents.
  bit         ram [0:255];
  bit         ref_mem [0:255];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic       pre_dat;

  crt_fb_scan_arbiter dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .sx         (sx),
    .sy         (sy),
    .de         (de),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_on     (pix_on),
    .frame_start(frame_start)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) begin
    if (pre_we) ram[pre_addr] <= pre_dat;
    else if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Expected lit state of screen pixel (x,y).
  function automatic bit exp_pix(input int x, input int y);
    if (x < 640 && y < 480) return ref_mem[(y / 80) * 40 + x / 16];
    return 1'b0;
  endfunction

  // A fetch happens when the pixel two clocks ahead is the first pixel of a visible cell.
  function automatic bit slot_of(input int x, input int y, output int addr);
    int nx;
    int ny;
    nx = x + 2;
    ny = y;
    if (nx >= 800) begin
      nx = nx - 800;
      ny = (y + 1) % 525;
    end
    addr = (ny / 80) * 40 + nx / 16;
    return (nx < 640) && (ny < 480) && (nx % 16 == 0);
  endfunction

  task automatic set_pos(input int x, input int y);
    sx = 10'(x);
    sy = 10'(y);
    de = (x < 640) && (y < 480);
    #1;
  endtask

  task automatic tick();
    psx = int'(sx);
    psy = int'(sy);
    @(posedge clk_pix);
    #1;
    if (sx == 10'd799) begin
      sx = 10'd0;
      sy = (sy == 10'd524) ? 10'd0 : sy + 10'd1;
    end else begin
      sx = sx + 10'd1;
    end
    de = (sx < 10'd640) && (sy < 10'd480);
    #1;
  endtask

  task automatic preload();
    for (int i = 0; i < 256; i++) begin
      pre_we   = 1'b1;
      pre_addr = 8'(i);
      pre_dat  = ref_mem[i];
      @(posedge clk_pix);
      #1;
    end
    pre_we = 1'b0;
  endtask

  // Runs the beam from (x0,y0) for n pixels checking slots, idle behaviour and pixels.
  task automatic scan_window(input int y0, input int x0, input int n);
    int  a;
    int  last_a;
    bit  s;
    bit  have_last;
    have_last = 1'b0;
    last_a    = 0;
    set_pos(x0, y0);
    for (int i = 0; i < n; i++) begin
      s = slot_of(int'(sx), int'(sy), a);
      total++;
      if (s) begin
        if (mem_addr !== 8'(a) || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
          bad++;
          $display("FAIL scan_slot sx=%0d sy=%0d: got addr=%0d we=%b rdy=%b, want addr=%0d we=0 rdy=0",
                   sx, sy, mem_addr, mem_we, wr_ready, a);
        end
        have_last = 1'b1;
        last_a    = a;
      end else begin
        if (mem_we !== 1'b0 || wr_ready !== 1'b1 || (have_last && mem_addr !== 8'(last_a))) begin
          bad++;
          $display("FAIL scan_free sx=%0d sy=%0d: got addr=%0d we=%b rdy=%b, want addr=%0d we=0 rdy=1",
                   sx, sy, mem_addr, mem_we, wr_ready, last_a);
        end
      end
      tick();
      total++;
      if (pix_on !== exp_pix(psx, psy) || frame_start !== (psx == 0 && psy == 0)) begin
        bad++;
        $display("FAIL scan_pix for sx=%0d sy=%0d: got pix_on=%b frame_start=%b, want %b %b",
                 psx, psy, pix_on, frame_start, exp_pix(psx, psy), (psx == 0 && psy == 0));
      end
    end
  endtask

  task automatic verify_all_rows();
    for (int r = 0; r < 6; r++) scan_window(r * 80 + 5, 640, 800);
  endtask

  task automatic test_reset();
    rst_pix_n = 1'b0;
    wr_valid  = 1'b1;
    wr_addr   = 8'd3;
    wr_data   = 1'b1;
    clr_req   = 1'b0;
    pre_we    = 1'b0;
    set_pos(0, 0);
    tick();
    total++;
    if (clr_busy !== 1'b0 || pix_on !== 1'b0 || frame_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_regs: got busy=%b pix=%b fs=%b, want 0 0 0", clr_busy, pix_on, frame_start);
    end
    total++;
    if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_gate: got rdy=%b we=%b, want 0 0", wr_ready, mem_we);
    end
    wr_valid = 1'b0;
    tick();
    rst_pix_n = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b0 || clr_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got rdy=%b we=%b busy=%b, want 1 0 0", wr_ready, mem_we, clr_busy);
    end
  endtask

  task automatic test_scan_basic();
    for (int i = 0; i < 256; i++) ref_mem[i] = (i < 240) ? 1'($urandom_range(0, 1)) : 1'b0;
    ref_mem[0] = 1'b1;
    ref_mem[1] = 1'b0;
    preload();
    scan_window(524, 780, 150);
  endtask

  task automatic test_row_boundary();
    ref_mem[40] = 1'b1;
    ref_mem[0]  = 1'b0;
    preload();
    scan_window(79, 700, 150);
  endtask

  task automatic test_contention();
    set_pos(28, 10);
    tick();
    tick();
    wr_valid = 1'b1;
    wr_addr  = 8'd5;
    wr_data  = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b0 || mem_addr !== 8'd2 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL contend_slot sx=%0d: got rdy=%b addr=%0d we=%b, want 0 2 0", sx, wr_ready, mem_addr, mem_we);
    end
    tick();
    total++;
    if (wr_ready !== 1'b1 || mem_addr !== 8'd5 || mem_we !== 1'b1 || mem_wdata !== 1'b1) begin
      bad++;
      $display("FAIL contend_write sx=%0d: got rdy=%b addr=%0d we=%b wd=%b, want 1 5 1 1",
               sx, wr_ready, mem_addr, mem_we, mem_wdata);
    end
    ref_mem[5] = 1'b1;
    tick();
    wr_valid = 1'b0;
    scan_window(10, 640, 260);
  endtask

  task automatic test_random_writes();
    int addr;
    int a;
    int x;
    int y;
    bit d;
    bit s;
    bit done;
    for (int n = 0; n < 30; n++) begin
      addr = $urandom_range(0, 255);
      d    = 1'($urandom_range(0, 1));
      y    = $urandom_range(0, 524);
      x    = (n < 10) ? 16 * $urandom_range(1, 39) - 2 : $urandom_range(0, 799);
      set_pos(x, y);
      wr_valid = 1'b1;
      wr_addr  = 8'(addr);
      wr_data  = d;
      #1;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        s = slot_of(int'(sx), int'(sy), a);
        total++;
        if (s) begin
          if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'(a)) begin
            bad++;
            $display("FAIL wr_stall sx=%0d sy=%0d: got rdy=%b we=%b addr=%0d, want 0 0 %0d",
                     sx, sy, wr_ready, mem_we, mem_addr, a);
          end
        end else begin
          if (wr_ready !== 1'b1 || mem_we !== (addr < 240) || mem_addr !== 8'(addr) ||
              (addr < 240 && mem_wdata !== d)) begin
            bad++;
            $display("FAIL wr_fire addr=%0d: got rdy=%b we=%b addr=%0d wd=%b, want 1 %b %0d %b",
                     addr, wr_ready, mem_we, mem_addr, mem_wdata, (addr < 240), addr, d);
          end
          if (addr < 240) ref_mem[addr] = d;
          done = 1'b1;
        end
        tick();
      end
      wr_valid = 1'b0;
      total++;
      if (!done) begin
        bad++;
        $display("FAIL wr_timeout addr=%0d: got no handshake in 20 cycles, want one", addr);
      end
    end
    verify_all_rows();
  endtask

  task automatic test_clear();
    int k;
    int busy;
    int slots;
    int a;
    bit s;
    set_pos(100, 200);
    clr_req = 1'b1;
    #1;
    tick();
    clr_req = 1'b0;
    k = 0;
    busy = 0;
    slots = 0;
    while (clr_busy === 1'b1 && busy < 2000) begin
      busy++;
      s = slot_of(int'(sx), int'(sy), a);
      total++;
      if (s) begin
        slots++;
        if (mem_we !== 1'b0 || mem_addr !== 8'(a) || wr_ready !== 1'b0) begin
          bad++;
          $display("FAIL clr_slot sx=%0d: got we=%b addr=%0d rdy=%b, want 0 %0d 0", sx, mem_we, mem_addr, wr_ready, a);
        end
      end else begin
        if (mem_we !== 1'b1 || mem_wdata !== 1'b0 || mem_addr !== 8'(k) || wr_ready !== 1'b0) begin
          bad++;
          $display("FAIL clr_write sx=%0d: got we=%b wd=%b addr=%0d rdy=%b, want 1 0 %0d 0",
                   sx, mem_we, mem_wdata, mem_addr, wr_ready, k);
        end
        k++;
      end
      tick();
    end
    total++;
    if (busy != 240 + slots) begin
      bad++;
      $display("FAIL clr_len: got busy cycles=%0d, want %0d", busy, 240 + slots);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 1'b0;
    verify_all_rows();
  endtask

  task automatic test_out_of_range_restart();
    int k;
    int a;
    int guard;
    bit s;
    set_pos(700, 0);
    wr_valid = 1'b1;
    wr_addr  = 8'd250;
    wr_data  = 1'b1;
    #1;
    total++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL oor_write: got rdy=%b we=%b, want 1 0", wr_ready, mem_we);
    end
    tick();
    wr_valid = 1'b0;
    tick();
    total++;
    if (ram[250] !== 1'b0) begin
      bad++;
      $display("FAIL oor_ram: got ram[250]=%b, want 0", ram[250]);
    end

    set_pos(200, 300);
    clr_req = 1'b1;
    #1;
    tick();
    clr_req = 1'b0;
    k = 0;
    for (int c = 0; c < 50; c++) begin
      if (!slot_of(int'(sx), int'(sy), a)) k++;
      tick();
    end
    guard = 0;
    while (slot_of(int'(sx), int'(sy), a) && guard < 4) begin
      tick();
      guard++;
    end
    clr_req = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 8'(k) || clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_cycle: got we=%b addr=%0d busy=%b, want 1 %0d 1", mem_we, mem_addr, clr_busy, k);
    end
    tick();
    clr_req = 1'b0;
    k = 0;
    guard = 0;
    while (clr_busy === 1'b1 && guard < 2000) begin
      guard++;
      s = slot_of(int'(sx), int'(sy), a);
      if (!s) begin
        total++;
        if (mem_addr !== 8'(k) || mem_we !== 1'b1) begin
          bad++;
          $display("FAIL restart_write: got addr=%0d we=%b, want %0d 1", mem_addr, mem_we, k);
        end
        k++;
      end
      tick();
    end
    total++;
    if (k != 240) begin
      bad++;
      $display("FAIL restart_count: got %0d writes after restart, want 240", k);
    end
  endtask

  task automatic test_async_reset();
    int a;
    int guard;
    bit seen_free;
    for (int i = 0; i < 256; i++) ref_mem[i] = (i < 240);
    preload();
    set_pos(40, 10);
    for (int c = 0; c < 10; c++) tick();
    clr_req = 1'b1;
    #1;
    tick();
    clr_req = 1'b0;
    tick();
    total++;
    if (clr_busy !== 1'b1 || pix_on !== 1'b1 || mem_we !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: got busy=%b pix=%b we=%b, want 1 1 1", clr_busy, pix_on, mem_we);
    end
    #1;
    rst_pix_n = 1'b0;
    #1;
    total++;
    if (clr_busy !== 1'b0 || pix_on !== 1'b0 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL areset_async: got busy=%b pix=%b rdy=%b we=%b, want 0 0 0 0",
               clr_busy, pix_on, wr_ready, mem_we);
    end
    tick();
    tick();
    #1;
    rst_pix_n = 1'b1;
    #1;
    guard = 0;
    seen_free = 1'b0;
    while (!slot_of(int'(sx), int'(sy), a) && guard < 40) begin
      if (!seen_free) begin
        total++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0 || mem_we !== 1'b0) begin
          bad++;
          $display("FAIL areset_idle: got rdy=%b busy=%b we=%b, want 1 0 0", wr_ready, clr_busy, mem_we);
        end
        seen_free = 1'b1;
      end
      tick();
      guard++;
    end
    total++;
    if (guard >= 40 || mem_addr !== 8'(a) || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL areset_fetch sx=%0d: got addr=%0d we=%b rdy=%b, want %0d 0 0", sx, mem_addr, mem_we, wr_ready, a);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    psx   = 0;
    psy   = 0;
    pre_addr = 8'd0;
    pre_dat  = 1'b0;
    test_reset();
    test_scan_basic();
    test_row_boundary();
    test_contention();
    test_random_writes();
    test_clear();
    test_out_of_range_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
